// File: rtl/pwl_act.sv
// Piecewise-linear activation unit: three-stage pipeline that picks a segment by
// first-match on breakpoints, applies a power-of-two slope and a bias, and
// saturates to DW bits. The segment table is runtime-loadable while the pipe is empty.
module pwl_act #(
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 9,
    parameter int unsigned NSEG = 16,
    parameter int unsigned SHW  = 5,
    localparam int unsigned AW  = $clog2(NSEG),
    localparam int unsigned CW  = 3 * DW + 1 + SHW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_y,
    input  logic          cfg_we,
    output logic          cfg_ready,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_wdata
);

    localparam logic [DW-1:0] BP_RST = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Y_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Y_MIN  = {1'b1, {(DW-1){1'b0}}};

    // FRAC only documents where the binary point sits; it must leave an integer bit.
    if (FRAC >= DW) begin : g_frac_out_of_range
    end

    // Segment table
    logic [DW-1:0]  bp_q    [NSEG];
    logic [DW-1:0]  base_q  [NSEG];
    logic [DW-1:0]  bias_q  [NSEG];
    logic           zero_q  [NSEG];
    logic [SHW-1:0] shift_q [NSEG];

    // Decoded write data
    logic [DW-1:0]  w_bp;
    logic [DW-1:0]  w_base;
    logic [DW-1:0]  w_bias;
    logic           w_zero;
    logic [SHW-1:0] w_shift;

    // Pipeline state
    logic           s1_valid_q;
    logic [DW-1:0]  s1_x_q;
    logic [DW-1:0]  s1_base_q;
    logic [DW-1:0]  s1_bias_q;
    logic           s1_zero_q;
    logic [SHW-1:0] s1_shift_q;
    logic           s2_valid_q;
    logic [DW:0]    s2_t_q;
    logic [DW-1:0]  s2_bias_q;
    logic           out_valid_q;
    logic [DW-1:0]  y_q;

    // Control
    logic           stall;
    logic           advance;
    logic           cfg_accept;
    logic           in_fire;
    logic [AW-1:0]  sel;

    // Datapath intermediates
    logic signed [DW:0] diff;
    logic [DW:0]        t_d;
    logic [DW+1:0]      sum;
    logic [DW-1:0]      y_d;

    assign {w_bp, w_base, w_bias, w_zero, w_shift} = cfg_wdata;

    // Handshake: one global enable; config only slips in when nothing is moving.
    assign stall      = out_valid_q & ~out_ready;
    assign advance    = ~stall;
    assign cfg_ready  = ~(s1_valid_q | s2_valid_q | out_valid_q) & ~in_valid;
    assign cfg_accept = cfg_we & cfg_ready;
    assign in_ready   = ~stall & ~cfg_accept;
    assign in_fire    = in_valid & in_ready;

    assign out_valid  = out_valid_q;
    assign out_y      = y_q;

    // Table storage: reset to "always match, output zero" entries, written on cfg_accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSEG); i++) begin
                bp_q[i]    <= BP_RST;
                base_q[i]  <= '0;
                bias_q[i]  <= '0;
                zero_q[i]  <= 1'b1;
                shift_q[i] <= '0;
            end
        end else if (cfg_accept) begin
            bp_q[cfg_addr]    <= w_bp;
            base_q[cfg_addr]  <= w_base;
            bias_q[cfg_addr]  <= w_bias;
            zero_q[cfg_addr]  <= w_zero;
            shift_q[cfg_addr] <= w_shift;
        end
    end

    // First-match segment select: scan downwards so the lowest matching index wins.
    always_comb begin
        sel = AW'(NSEG - 1);
        for (int i = int'(NSEG) - 1; i >= 0; i--) begin
            if ($signed(in_x) < $signed(bp_q[i])) begin
                sel = AW'(i);
            end
        end
    end

    // Stage 1: capture the sample together with its selected entry fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_base_q  <= '0;
            s1_bias_q  <= '0;
            s1_zero_q  <= 1'b1;
            s1_shift_q <= '0;
        end else if (advance) begin
            s1_valid_q <= in_fire;
            s1_x_q     <= in_x;
            s1_base_q  <= base_q[sel];
            s1_bias_q  <= bias_q[sel];
            s1_zero_q  <= zero_q[sel];
            s1_shift_q <= shift_q[sel];
        end
    end

    // Stage 2 logic: offset by base at DW+1 bits, then arithmetic shift (sign fill if too far).
    always_comb begin
        diff = {s1_x_q[DW-1], s1_x_q} - {s1_base_q[DW-1], s1_base_q};
        if (s1_zero_q) begin
            t_d = '0;
        end else if (32'(s1_shift_q) >= DW + 1) begin
            t_d = {(DW+1){diff[DW]}};
        end else begin
            t_d = diff >>> s1_shift_q;
        end
    end

    // Stage 2: register scaled value and bias.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_t_q     <= '0;
            s2_bias_q  <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_t_q     <= t_d;
            s2_bias_q  <= s1_bias_q;
        end
    end

    // Stage 3 logic: add bias at DW+2 bits and clamp when the top three bits disagree.
    always_comb begin
        sum = {s2_t_q[DW], s2_t_q} + {{2{s2_bias_q[DW-1]}}, s2_bias_q};
        if (sum[DW+1:DW-1] == 3'b000 || sum[DW+1:DW-1] == 3'b111) begin
            y_d = sum[DW-1:0];
        end else if (sum[DW+1]) begin
            y_d = Y_MIN;
        end else begin
            y_d = Y_MAX;
        end
    end

    // Stage 3: output register, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid_q;
            y_q         <= y_d;
        end
    end

endmodule

// File: tb/tb_pwl_act.sv
// Bench for pwl_act: directed scenarios with literal expectations plus a randomized
// stream scored against a plain-arithmetic model of the activation table.
module tb_pwl_act;

    localparam int unsigned DW   = 16;
    localparam int unsigned NSEG = 16;
    localparam int unsigned SHW  = 5;
    localparam int unsigned AW   = 4;
    localparam int unsigned CW   = 3 * DW + 1 + SHW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_y;
    logic          cfg_we = 1'b0;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_wdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwl_act #(
        .DW   (DW),
        .FRAC (9),
        .NSEG (NSEG),
        .SHW  (SHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference table and model
    logic [15:0] m_bp    [NSEG];
    logic [15:0] m_base  [NSEG];
    logic [15:0] m_bias  [NSEG];
    logic        m_zero  [NSEG];
    logic [4:0]  m_shift [NSEG];

    function automatic void model_reset();
        for (int i = 0; i < int'(NSEG); i++) begin
            m_bp[i] = 16'h7FFF; m_base[i] = '0; m_bias[i] = '0; m_zero[i] = 1'b1; m_shift[i] = '0;
        end
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
        {m_bp[a], m_base[a], m_bias[a], m_zero[a], m_shift[a]} = d;
    endfunction

    function automatic logic [15:0] model_y(input logic [15:0] x);
        int sel;
        int t;
        int s;
        bit found;
        sel = NSEG - 1;
        found = 0;
        for (int i = 0; i < int'(NSEG); i++) begin
            if (!found && $signed(x) < $signed(m_bp[i])) begin
                sel = i;
                found = 1;
            end
        end
        if (m_zero[sel]) begin
            t = 0;
        end else begin
            t = int'($signed(x)) - int'($signed(m_base[sel]));
            if (m_shift[sel] >= 17) t = (t < 0) ? -1 : 0;
            else t = t >>> m_shift[sel];
        end
        s = t + int'($signed(m_bias[sel]));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    function automatic logic [CW-1:0] pack(input logic [15:0] bp, input logic [15:0] base,
                                           input logic [15:0] bias, input logic z,
                                           input logic [4:0] sh);
        return {bp, base, bias, z, sh};
    endfunction

    // Scoreboard: every cycle, compare handshakes, hold behaviour and output order.
    logic [15:0] q[$];
    bit          held = 0;
    logic [15:0] held_y;
    int          n_out = 0;
    logic        exp_cfg_ready;
    logic        exp_in_ready;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            model_reset();
            held = 0;
        end else begin
            exp_cfg_ready = (q.size() == 0) && !in_valid;
            exp_in_ready  = !(out_valid && !out_ready) && !(cfg_we && exp_cfg_ready);
            check("cfg_ready", cfg_ready, exp_cfg_ready);
            check("in_ready", in_ready, exp_in_ready);
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_y", out_y, held_y);
            end
            if (out_valid) begin
                check("out_has_pending", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    check("out_y", out_y, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && exp_in_ready) q.push_back(model_y(in_x));
            if (cfg_we && exp_cfg_ready) model_write(cfg_addr, cfg_wdata);
            held   = out_valid && !out_ready;
            held_y = out_y;
        end
    end

    // Directed helpers
    logic [15:0] bx   [8];
    logic [15:0] bexp [8];

    task automatic cfg_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1;
                break;
            end
        end
        check("cfg_accept_timeout", ok, 1);
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    // Back-to-back burst with exact-cycle expectations: idle for 3 cycles, then n results.
    task automatic burst(input int n);
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    in_valid = 1; in_x = bx[k];
                    @(posedge clk); #1;
                end
                in_valid = 0;
            end
            begin
                for (int j = 0; j < n + 3; j++) begin
                    @(negedge clk);
                    if (j < 3) begin
                        check("burst_latency_idle", out_valid, 0);
                    end else begin
                        check("burst_valid", out_valid, 1);
                        check("burst_y", out_y, bexp[j-3]);
                    end
                end
            end
        join
    endtask

    task automatic send(input logic [DW-1:0] x);
        bit ok;
        ok = 0;
        in_valid = 1; in_x = x;
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_timeout", ok, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic load_test_table();
        cfg_write(0, pack(16'hF000, 16'h0000, 16'h0000, 1'b1, 5'd0));
        cfg_write(1, pack(16'h0230, 16'hFDD0, 16'h0038, 1'b0, 5'd2));
        for (int a = 2; a < int'(NSEG); a++) begin
            cfg_write(AW'(a), pack(16'h7FFF, 16'h0000, 16'h0200, 1'b1, 5'd0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit seen;
        bit drv_done;
        int n_out0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);

        // Scenario 1: test table, single sample, exact 3-cycle latency
        load_test_table();
        check("model_pin_0000", model_y(16'h0000), 16'h00C4);
        check("model_pin_FE00", model_y(16'hFE00), 16'h0044);
        check("model_pin_7FFF", model_y(16'h7FFF), 16'h0200);
        bx[0] = 16'h0000; bexp[0] = 16'h00C4;
        burst(1);

        // Scenario 2: four samples back to back
        bx[0] = 16'hE000; bexp[0] = 16'h0000;
        bx[1] = 16'hFE00; bexp[1] = 16'h0044;
        bx[2] = 16'h0500; bexp[2] = 16'h0200;
        bx[3] = 16'h7FFF; bexp[3] = 16'h0200;
        burst(4);

        // Scenario 3: positive and negative saturation
        cfg_write(1, pack(16'h7FFF, 16'h0000, 16'h7F00, 1'b0, 5'd0));
        bx[0] = 16'h1000; bexp[0] = 16'h7FFF;
        burst(1);
        cfg_write(1, pack(16'h7FFF, 16'h0000, 16'h8100, 1'b0, 5'd0));
        bx[0] = 16'hF100; bexp[0] = 16'h8000;
        burst(1);

        // Scenario 5: sample and config write collide; sample goes first with the old entry
        @(posedge clk); #1;
        in_valid = 1; in_x = 16'h1000;
        cfg_we = 1; cfg_addr = 1; cfg_wdata = pack(16'h7FFF, 16'h0000, 16'h0100, 1'b0, 5'd3);
        @(negedge clk);
        check("s5_cfg_blocked", cfg_ready, 0);
        check("s5_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        ok = 0; seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                check("s5_old_entry", out_y, 16'h9100);
            end
            if (cfg_ready) begin
                ok = 1;
                break;
            end
        end
        check("s5_seen_old", seen, 1);
        check("s5_cfg_accepted", ok, 1);
        @(posedge clk); #1;
        cfg_we = 0;
        bx[0] = 16'h1000; bexp[0] = 16'h0300;
        burst(1);

        // Scenario 4: random table, 200 random samples, random backpressure
        for (int a = 0; a < int'(NSEG); a++) begin
            cfg_write(AW'(a), pack(16'($urandom), 16'($urandom), 16'($urandom),
                                   ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31))));
        end
        n_out0 = n_out;
        drv_done = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    case ($urandom_range(0, 5))
                        0:       send(16'h7FFF);
                        1:       send(16'h8000);
                        default: send(16'($urandom));
                    endcase
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 99) < 60);
                end
            end
        join
        out_ready = 1;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("rand_drained", q.size(), 0);
        check("rand_out_count", n_out - n_out0, 200);

        // Scenario 6: reset with three samples in flight clears pipe and table
        load_test_table();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_x = 16'h0500;
            @(posedge clk); #1;
        end
        in_valid = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("s6_out_valid", out_valid, 0);
        check("s6_out_y", out_y, 0);
        check("s6_in_ready", in_ready, 1);
        check("s6_cfg_ready", cfg_ready, 1);
        bx[0] = 16'h0500; bexp[0] = 16'h0000;
        bx[1] = 16'h8000; bexp[1] = 16'h0000;
        bx[2] = 16'h0000; bexp[2] = 16'h0000;
        burst(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
